pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//  Parametrised successor of the 1-bit full adder: a WIDTH-bit add/subtract unit built from
//  full-adder ripple chunks, with a register between STAGES pipeline stages.
//  Valid/ready handshake on input and output, with per-stage backpressure and bubble collapse.
//  Used as the datapath arithmetic primitive wherever a registered multi-bit add is needed.
// PARAMETERS
//  WIDTH   16  operand/sum width in bits; must be a multiple of STAGES
//  STAGES  4   pipeline stages; each stage resolves CHUNK = WIDTH/STAGES bits; 1 <= STAGES <= WIDTH
// PORTS
//  CLK         in   1      clock, rising edge
//  ASYNCRESET  in   1      asynchronous, active-high reset
//  in_valid    in   1      operand beat valid
//  in_ready    out  1      stage 0 can accept a beat
//  a           in   WIDTH  operand A
//  b           in   WIDTH  operand B
//  cin         in   1      carry-in (add) / borrow-in (sub)
//  sub         in   1      0: a+b+cin; 1: a-b-cin
//  out_valid   out  1      result beat valid
//  out_ready   in   1      consumer accepts result
//  sum         out  WIDTH  result, modulo 2^WIDTH
//  cout        out  1      carry out of MSB (sub: 1 = no borrow)
//  overflow    out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Reset (async assert, sync release): all stage valid bits 0; all data/carry registers 0.
//    Result: out_valid=0, sum=0, cout=0, overflow=0; in_ready=1 on the first cycle after release.
//  - Effective operands at capture: bb = sub ? ~b : b; c0 = sub ? ~cin : cin.
//  - Stage k (0..STAGES-1): ripple-adds bits [k*CHUNK +: CHUNK] of a and bb plus the registered
//    carry from stage k-1 (stage 0 uses c0). Registers the resolved low sum bits, the carry,
//    and the not-yet-added upper slices of a and bb.
//  - Last stage also registers carry-into-MSB so overflow can be computed.
//  - No combinational path from the a/b slices of one stage to any other stage.
//  - Latency: exactly STAGES cycles from input handshake to out_valid when there is no stall.
//    Throughput: 1 beat/cycle.
//  - Handshake: a beat transfers when valid && ready. Stage k loads when (!v[k] || adv[k+1]);
//    adv[STAGES] = out_ready. in_ready = !v[0] || adv[1].
//    in_ready depends on out_ready combinationally; there is no path from in_valid to in_ready.
//  - Bubble collapse: an empty stage always accepts, even when downstream is stalled.
//  - While out_valid && !out_ready, sum/cout/overflow hold stable. Once asserted, out_valid is
//    not dropped without a handshake.
//  - Each beat carries its own sub/cin; add and sub beats may be interleaved back to back.
//  - Wrap-around: sum is modulo 2^WIDTH; a carry beyond the MSB appears only on cout.
//  - Reset mid-operation: all in-flight beats are discarded; no partial result is ever emitted.
//  - STAGES=1: purely one registered WIDTH-bit ripple; latency 1.
// STRUCTURE
//  - Package pipelined_adder_pkg: function chunk_w(WIDTH,STAGES); elaboration-time check that
//    WIDTH % STAGES == 0 (fatal otherwise); typedef for the stage payload
//    {a_hi, b_hi, sum_lo, carry, cmsb}.
//  - Sub-module adder_chunk: combinational CHUNK-bit ripple of full-adder cells
//    (xor/and/or per bit); outputs sum, carry out, carry into top bit.
//  - Top level: STAGES instances of adder_chunk in a generate loop, plus stage registers and
//    the valid/ready chain.
// TESTING (WIDTH=16, STAGES=4 unless noted)
//  1. a=0x1234, b=0x4321, cin=0, sub=0, out_ready=1 -> 4 cycles later sum=0x5555, cout=0, ovf=0.
//  2. a=0xFFFF, b=0x0001, cin=0, add -> sum=0x0000, cout=1, ovf=0.
//     a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
//  3. sub: a=0x0005, b=0x0007, cin=0 -> sum=0xFFFE, cout=0 (borrow), ovf=0.
//     a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
//  4. Stream 8 beats back to back with out_ready held 0 -> in_ready falls after 4 accepted.
//     Release out_ready -> results emitted in order, one per cycle; none lost or duplicated.
//  5. Assert ASYNCRESET mid-clock with 3 beats in flight -> out_valid=0 and sum=0 immediately.
//     After release, no stale result appears.
//  6. Random a/b/cin/sub with random in_valid/out_ready, for STAGES in {1,2,4,16}:
//     scoreboard against {cout,sum} = a +/- b +/- cin; checker flags out_valid dropping while
//     stalled.

Source files
------------

// File: rtl/pipelined_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipelined_adder_pkg
//   Shared elaboration-time helpers for the pipelined add/subtract unit.
//   chunk_w   : number of operand bits resolved by one pipeline stage.
//   params_ok : legality of a WIDTH/STAGES pairing. STAGES must lie in
//               1..WIDTH and must divide WIDTH evenly.
//   The per-stage payload struct is declared inside pipelined_adder because its
//   field widths follow that module's WIDTH parameter.
// -----------------------------------------------------------------------------
package pipelined_adder_pkg;

    // Bits resolved per stage.
    function automatic int chunk_w(input int width, input int stages);
        return width / stages;
    endfunction

    // A pairing is legal when every stage gets the same non-zero slice.
    function automatic bit params_ok(input int width, input int stages);
        return (stages >= 32'sd1) && (stages <= width) && ((width % stages) == 32'sd0);
    endfunction

endpackage

// File: rtl/adder_chunk.sv
// -----------------------------------------------------------------------------
// adder_chunk
//   Combinational CHUNK-bit ripple of full-adder cells.
//   Ports:
//     a_i, b_i  [CHUNK] operand slices (b_i is already inverted for subtract)
//     c_i       [1]     carry into bit 0
//     s_o       [CHUNK] sum slice
//     c_o       [1]     carry out of the top bit
//     cmsb_o    [1]     carry into the top bit (feeds the signed-overflow test)
// -----------------------------------------------------------------------------
module adder_chunk
    import pipelined_adder_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] a_i,
    input  logic [CHUNK-1:0] b_i,
    input  logic             c_i,
    output logic [CHUNK-1:0] s_o,
    output logic             c_o,
    output logic             cmsb_o
);

    // c_s[i] is the carry into bit i; c_s[CHUNK] leaves the slice.
    logic [CHUNK:0] c_s;

    // Full-adder cells chained bit by bit.
    always_comb begin
        c_s    = '0;
        s_o    = '0;
        c_s[0] = c_i;
        for (int i = 32'sd0; i < CHUNK; i++) begin
            s_o[i]   = a_i[i] ^ b_i[i] ^ c_s[i];
            c_s[i+1] = (a_i[i] & b_i[i]) | (c_s[i] & (a_i[i] ^ b_i[i]));
        end
    end

    assign c_o    = c_s[CHUNK];
    assign cmsb_o = c_s[CHUNK-1];

endmodule

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//   WIDTH-bit add/subtract unit. It is split into STAGES registered ripple
//   chunks and uses valid/ready flow control with per-stage backpressure.
//   An empty stage always accepts a beat, so gaps in the pipeline collapse.
//   Ports:
//     CLK, ASYNCRESET   clock (rising edge), asynchronous active-high reset
//     in_valid/in_ready operand handshake
//     a, b   [WIDTH]    operands
//     cin               carry-in (add) / borrow-in (sub)
//     sub               0: a+b+cin, 1: a-b-cin
//     out_valid/out_ready result handshake
//     sum    [WIDTH]    result modulo 2^WIDTH
//     cout              carry out of MSB (sub: 1 = no borrow)
//     overflow          signed overflow
// -----------------------------------------------------------------------------
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             CLK,
    input  logic             ASYNCRESET,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    localparam int CHUNK = chunk_w(WIDTH, STAGES);

    if (!params_ok(WIDTH, STAGES)) begin : g_bad_params
        $fatal(1, "pipelined_adder: STAGES must divide WIDTH and lie in 1..WIDTH");
    end

    // Payload carried between stages. Operand fields keep only the slices that
    // are still waiting to be added; consumed slices are cleared.
    typedef struct packed {
        logic [WIDTH-1:0] a_hi;
        logic [WIDTH-1:0] b_hi;
        logic [WIDTH-1:0] sum_lo;
        logic             carry;
        logic             cmsb;
    } stage_pl_t;

    logic [STAGES-1:0] v_s;              // valid bit of each stage register
    logic [STAGES:0]   ld_s;             // stage k may load this cycle
    stage_pl_t         pl_s [STAGES];    // registered payload of each stage
    stage_pl_t         pl_in_s;          // effective operands entering stage 0
    logic              unused_operands_s;

    // Load-enable chain: an empty stage always loads, and a full stage loads
    // only when its content moves on downstream. The chain starts at out_ready,
    // so in_ready depends on out_ready and never on in_valid.
    always_comb begin
        ld_s         = '0;
        ld_s[STAGES] = out_ready;
        for (int k = STAGES - 32'sd1; k >= 32'sd0; k--) begin
            ld_s[k] = !v_s[k] || ld_s[k+1];
        end
    end

    // Subtract is handled as a + ~b + ~cin.
    always_comb begin
        pl_in_s       = '0;
        pl_in_s.a_hi  = a;
        pl_in_s.b_hi  = sub ? ~b : b;
        pl_in_s.carry = sub ? ~cin : cin;
    end

    assign in_ready = ld_s[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_pl_t        up_s;
        stage_pl_t        pl_d;
        stage_pl_t        pl_q;
        logic             up_valid_s;
        logic             v_q;
        logic [CHUNK-1:0] s_s;
        logic             co_s;
        logic             cm_s;

        if (k == 0) begin : g_first
            assign up_s       = pl_in_s;
            assign up_valid_s = in_valid;
        end else begin : g_next
            assign up_s       = pl_s[k-1];
            assign up_valid_s = v_s[k-1];
        end

        adder_chunk #(
            .CHUNK (CHUNK)
        ) u_chunk (
            .a_i    (up_s.a_hi[k*CHUNK +: CHUNK]),
            .b_i    (up_s.b_hi[k*CHUNK +: CHUNK]),
            .c_i    (up_s.carry),
            .s_o    (s_s),
            .c_o    (co_s),
            .cmsb_o (cm_s)
        );

        // Merge this stage's resolved slice into the payload and clear the consumed operand bits.
        always_comb begin
            pl_d                            = up_s;
            pl_d.a_hi[k*CHUNK +: CHUNK]     = '0;
            pl_d.b_hi[k*CHUNK +: CHUNK]     = '0;
            pl_d.sum_lo[k*CHUNK +: CHUNK]   = s_s;
            pl_d.carry                      = co_s;
            pl_d.cmsb                       = cm_s;
        end

        // Stage register: cleared by reset, loaded whenever the handshake chain allows it.
        always_ff @(posedge CLK or posedge ASYNCRESET) begin
            if (ASYNCRESET) begin
                v_q  <= 1'b0;
                pl_q <= '0;
            end else if (ld_s[k]) begin
                v_q  <= up_valid_s;
                pl_q <= pl_d;
            end
        end

        assign v_s[k]  = v_q;
        assign pl_s[k] = pl_q;
    end

    // The last stage's operand fields have no consumer. Every slice has been
    // cleared by then, so these fields only ever hold zeros.
    assign unused_operands_s = ^{pl_s[STAGES-1].a_hi, pl_s[STAGES-1].b_hi};

    assign out_valid = v_s[STAGES-1];
    assign sum       = pl_s[STAGES-1].sum_lo;
    assign cout      = pl_s[STAGES-1].carry;
    assign overflow  = pl_s[STAGES-1].carry ^ pl_s[STAGES-1].cmsb;

endmodule

// File: tb/tb_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder
//   Four instances of pipelined_adder (WIDTH=16, STAGES 1/2/4/16) share one
//   stimulus stream. A falling-edge monitor keeps a per-instance queue of
//   expected results. The queue is filled from an arithmetic reference model
//   and is checked on every output handshake and every stalled cycle.
// -----------------------------------------------------------------------------
module tb_pipelined_adder;

    localparam int W  = 16;
    localparam int ND = 4;

    function automatic int stages_of(input int d);
        case (d)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return 16;
        endcase
    endfunction

    logic         CLK = 1'b0;
    logic         ASYNCRESET;
    logic         in_valid;
    logic         out_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;

    logic         in_ready_s  [ND];
    logic         out_valid_s [ND];
    logic [W-1:0] sum_s       [ND];
    logic         cout_s      [ND];
    logic         ovf_s       [ND];

    int           tests = 0;
    int           fails = 0;
    logic [W+1:0] sb_q [ND][$];
    int           acc_cnt    [ND];
    logic         prev_stall [ND];
    logic [W+1:0] prev_res   [ND];

    always #5 CLK = ~CLK;

    for (genvar g = 0; g < ND; g++) begin : g_dut
        pipelined_adder #(
            .WIDTH  (W),
            .STAGES (stages_of(g))
        ) u_dut (
            .CLK        (CLK),
            .ASYNCRESET (ASYNCRESET),
            .in_valid   (in_valid),
            .in_ready   (in_ready_s[g]),
            .a          (a),
            .b          (b),
            .cin        (cin),
            .sub        (sub),
            .out_valid  (out_valid_s[g]),
            .out_ready  (out_ready),
            .sum        (sum_s[g]),
            .cout       (cout_s[g]),
            .overflow   (ovf_s[g])
        );
    end

    // Reference: plain integer arithmetic. The result packs {overflow, cout, sum}.
    function automatic logic [W+1:0] model(input logic [W-1:0] xa, input logic [W-1:0] xb,
                                           input logic xc, input logic xs);
        int           ua, ub, sa, sb, ur, sr;
        logic         co, ov;
        logic [W-1:0] s;
        ua = int'(xa);
        ub = int'(xb);
        sa = int'($signed(xa));
        sb = int'($signed(xb));
        if (xs) begin
            ur = ua - ub - int'(xc);
            sr = sa - sb - int'(xc);
            co = (ur >= 0);
        end else begin
            ur = ua + ub + int'(xc);
            sr = sa + sb + int'(xc);
            co = (ur >= 65536);
        end
        s  = ur[W-1:0];
        ov = (sr > 32767) || (sr < -32768);
        return {ov, co, s};
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard and stall monitor: handshakes are sampled at the falling edge, before the rising edge commits them.
    always @(negedge CLK) begin
        logic [W+1:0] got;
        logic [W+1:0] exp_r;
        for (int d = 0; d < ND; d++) begin
            if (ASYNCRESET === 1'b1) begin
                prev_stall[d] = 1'b0;
            end else begin
                got = {ovf_s[d], cout_s[d], sum_s[d]};
                if (prev_stall[d]) begin
                    check($sformatf("stall_valid_held_dut%0d", d), int'(out_valid_s[d]), 1);
                    check($sformatf("stall_result_held_dut%0d", d), int'(got), int'(prev_res[d]));
                end
                if (out_valid_s[d] === 1'b1 && out_ready === 1'b1) begin
                    check($sformatf("pop_expected_dut%0d", d), (sb_q[d].size() > 0) ? 1 : 0, 1);
                    if (sb_q[d].size() > 0) begin
                        exp_r = sb_q[d].pop_front();
                        check($sformatf("result_dut%0d", d), int'(got), int'(exp_r));
                    end
                end
                if (in_valid === 1'b1 && in_ready_s[d] === 1'b1) begin
                    sb_q[d].push_back(model(a, b, cin, sub));
                    acc_cnt[d]++;
                end
                prev_stall[d] = out_valid_s[d] && !out_ready;
                prev_res[d]   = got;
            end
        end
    end

    // One beat with no stall: latency must equal STAGES, and the result must match the given constants.
    task automatic single_beat(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                               input logic xs, input logic [W-1:0] es, input logic ec,
                               input logic eo, input string name);
        int lat [ND];
        int res [ND];
        @(posedge CLK); #1;
        a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1; out_ready = 1'b1;
        for (int d = 0; d < ND; d++) begin
            lat[d] = 0;
            res[d] = 0;
        end
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge CLK); #1;
            if (cyc == 1) in_valid = 1'b0;
            for (int d = 0; d < ND; d++) begin
                if (lat[d] == 0 && out_valid_s[d] === 1'b1) begin
                    lat[d] = cyc;
                    res[d] = int'({ovf_s[d], cout_s[d], sum_s[d]});
                end
            end
        end
        for (int d = 0; d < ND; d++) begin
            check($sformatf("%s_latency_dut%0d", name, d), lat[d], stages_of(d));
            check($sformatf("%s_value_dut%0d", name, d), res[d], int'({eo, ec, es}));
        end
    endtask

    initial begin
        int run;
        int seen;
        bit done;
        ASYNCRESET = 1'b1;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        a          = 16'h0000;
        b          = 16'h0000;
        cin        = 1'b0;
        sub        = 1'b0;
        for (int d = 0; d < ND; d++) begin
            acc_cnt[d]    = 0;
            prev_stall[d] = 1'b0;
            prev_res[d]   = '0;
        end

        // Reset state
        repeat (3) @(posedge CLK);
        #1;
        for (int d = 0; d < ND; d++)
            check($sformatf("reset_outputs_dut%0d", d),
                  int'({out_valid_s[d], ovf_s[d], cout_s[d], sum_s[d]}), 0);
        ASYNCRESET = 1'b0;
        #1;
        for (int d = 0; d < ND; d++)
            check($sformatf("ready_after_reset_dut%0d", d), int'(in_ready_s[d]), 1);

        // Directed arithmetic corners
        single_beat(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, "add_basic");
        single_beat(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, "add_wrap");
        single_beat(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, "add_ovf");
        single_beat(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, "sub_borrow");
        single_beat(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, "sub_ovf");
        single_beat(16'h0000, 16'h0000, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0, "sub_borrow_in");

        // Backpressure: stream beats into a stalled output
        @(posedge CLK); #1;
        out_ready = 1'b0;
        for (int d = 0; d < ND; d++) acc_cnt[d] = 0;
        for (int i = 0; i < 10; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("stall_accepted_dut%0d", d), acc_cnt[d],
                  (stages_of(d) < 10) ? stages_of(d) : 10);
            check($sformatf("stall_in_ready_dut%0d", d), int'(in_ready_s[d]),
                  (stages_of(d) <= 10) ? 0 : 1);
        end
        out_ready = 1'b1;
        run  = 0;
        done = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!done) begin
                if (out_valid_s[2] === 1'b1) run++;
                else done = 1'b1;
            end
            @(posedge CLK); #1;
        end
        check("drain_consecutive_dut2", run, 4);
        for (int d = 0; d < ND; d++)
            check($sformatf("drain_empty_dut%0d", d), sb_q[d].size(), 0);

        // Reset with beats in flight
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            @(posedge CLK); #1;
        end
        in_valid = 1'b0;
        @(posedge CLK); #1;
        check("inflight_before_reset_dut2", int'(out_valid_s[2]), 1);
        #2;
        ASYNCRESET = 1'b1;
        #1;
        for (int d = 0; d < ND; d++) begin
            check($sformatf("midreset_valid_dut%0d", d), int'(out_valid_s[d]), 0);
            check($sformatf("midreset_sum_dut%0d", d), int'(sum_s[d]), 0);
            sb_q[d].delete();
        end
        @(posedge CLK); #1;
        ASYNCRESET = 1'b0;
        out_ready  = 1'b1;
        #1;
        for (int d = 0; d < ND; d++)
            check($sformatf("ready_after_midreset_dut%0d", d), int'(in_ready_s[d]), 1);
        seen = 0;
        repeat (30) begin
            @(posedge CLK); #1;
            for (int d = 0; d < ND; d++) if (out_valid_s[d] === 1'b1) seen++;
        end
        check("no_stale_after_reset", seen, 0);

        // Random traffic, checked by the monitor
        for (int i = 0; i < 3000; i++) begin
            a = 16'($urandom); b = 16'($urandom);
            cin = 1'($urandom_range(0, 1)); sub = 1'($urandom_range(0, 1));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            @(posedge CLK); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(posedge CLK);
        #1;
        for (int d = 0; d < ND; d++)
            check($sformatf("random_all_delivered_dut%0d", d), sb_q[d].size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached (tests=%0d failed=%0d)", tests, fails);
        $fatal(1, "watchdog");
    end

endmodule
